afifo_wr_arbiter: RTL and testbench
===================================

AFIFO_WR_ARBITER -- requirements
Module: afifo_wr_arbiter

Interface
- REQ-001: Parameter DATA_WIDTH, default 32, width of each requester's data and of wdata.
- REQ-002: Parameter NUM_REQ, default 4, number of requesters; legal range 2..16.
- REQ-003: Parameter MAX_BURST, default 8, maximum beats per grant tenure; legal range 1..255.
- REQ-004: The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
  - wclk  in  1  write-domain clock; all state on rising edge.
  - wrst  in  1  synchronous active-high reset.
  - req  in  NUM_REQ  per-requester beat-valid.
  - req_data  in  NUM_REQ*DATA_WIDTH  packed requester data; slice i = [i*DATA_WIDTH +: DATA_WIDTH].
  - gnt  out  NUM_REQ  one-hot-or-zero; gnt[i]=1 means requester i's beat is written this cycle.
  - winc  out  1  FIFO write enable.
  - wdata  out  DATA_WIDTH  FIFO write data.
  - wfull  in  1  FIFO full flag, write domain.
  - owner  out  $clog2(NUM_REQ)  current tenure owner; 0 when idle.
  - busy  out  1  high while in BURST.

Function
- REQ-005: Two-state FSM: IDLE, BURST.
- REQ-006: In IDLE, gnt=0 and winc=0. If any req bit is high, pick the first set bit searching upward from rr_ptr with wrap. Latch it into owner, clear beat_cnt, and go to BURST next cycle.
- REQ-007: In BURST, gnt[owner] = req[owner] & ~wfull and all other gnt bits are 0. winc = |gnt. wdata = req_data slice of owner. All are combinational from state, req and wfull (zero-cycle transfer latency).
- REQ-008: Each transfer increments beat_cnt; beat_cnt width is $clog2(MAX_BURST+1) and SHALL never exceed MAX_BURST.
- REQ-009: BURST exits to IDLE at the edge after either of these:
  - req[owner]=0 (release, with or without wfull); or
  - a transfer that makes beat_cnt equal MAX_BURST.
- REQ-010: On BURST exit, rr_ptr = owner+1, wrapping NUM_REQ-1 to 0.
- REQ-011: While wfull=1 with req[owner]=1, the block SHALL hold state, owner and beat_cnt, with winc=0. It SHALL never assert winc while wfull=1.
- REQ-012: Requests from non-owners during BURST are ignored; they compete at the next IDLE cycle.
- REQ-013: With MAX_BURST=1, every tenure is exactly one beat followed by one IDLE cycle.
- REQ-014: Single requester continuously requesting with wfull=0 gets MAX_BURST beats per MAX_BURST+1 cycles.

Reset
- REQ-015: When wrst=1 at a clock edge, the next state is IDLE with owner=0, rr_ptr=0, beat_cnt=0 and stall_cnt=0 (if present).
- REQ-016: While in reset, gnt=0, winc=0, wdata=0 and busy=0, regardless of req and wfull.
- REQ-017: Reset asserted mid-burst SHALL drop the tenure; no beat is written in the reset cycle.

Configuration
- REQ-018: Macro AFIFO_WR_ARB_STALL_CNT_EN.
  - Defined: the block adds output stall_cnt[15:0], which increments each cycle that busy=1, req[owner]=1 and wfull=1. It saturates at 16'hFFFF and clears only on reset.
  - Undefined: the port and counter are absent; all other behaviour is identical.

Structure
- REQ-019: Package afifo_arb_pkg SHALL hold the FSM state enum (IDLE, BURST) and the stall counter width constant (16).
- REQ-020: The round-robin search SHALL be a combinational sub-module afifo_rr_pick with inputs req and rr_ptr and outputs winner index and valid.

Verification
- REQ-021: The bench SHALL cover these directed scenarios:
  - V1: NUM_REQ=4, MAX_BURST=8, req=4'b0001 held 20 cycles, wfull=0 -> gnt[0] for 8 cycles, 1 IDLE cycle, 8 more; 16 writes total in cycles 1-8 and 10-17.
  - V2: req=4'b1111 held, wfull=0 -> owners in order 0,1,2,3,0, each granted 8 consecutive beats.
  - V3: owner 2 mid-burst after 3 beats, wfull=1 for 5 cycles -> winc=0, beat_cnt stays 3, owner stays 2; after wfull drops, 5 more beats, then rr_ptr=3.
  - V4: owner 1 drops req after 2 beats while req[3]=1 -> IDLE for 1 cycle, then owner=3; wdata equals slice 3.
  - V5: wrst=1 for 1 cycle during owner 0's 4th beat -> winc=0 in that cycle; next cycle IDLE, owner=0, rr_ptr=0.
  - V6: with AFIFO_WR_ARB_STALL_CNT_EN defined, wfull=1 for 10 cycles during a held burst -> stall_cnt=10; forced to 16'hFFFF, it holds.

Source files
------------

// File: rtl/afifo_arb_pkg.sv
// Shared types and constants for the async-FIFO write-side arbiter.
package afifo_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StBurst
  } arb_state_e;

  localparam int unsigned StallCntW = 16;

endpackage

// File: rtl/afifo_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr, wrapping.
module afifo_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    rr_ptr,
  output logic [IdxW-1:0]    winner,
  output logic               valid
);

  logic [IdxW:0]   sum;
  logic [IdxW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // rr_ptr and k are both below NUM_REQ, so one subtraction wraps the sum.
      sum = {1'b0, rr_ptr} + (IdxW+1)'(k);
      if (sum >= (IdxW+1)'(NUM_REQ)) begin
        sum = sum - (IdxW+1)'(NUM_REQ);
      end
      idx = sum[IdxW-1:0];
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Round-robin burst arbiter feeding an async FIFO write port.
// Optional stall counter output enabled by AFIFO_WR_ARB_STALL_CNT_EN.
module afifo_wr_arbiter
  import afifo_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_BURST  = 8,
  localparam int unsigned IdxW = $clog2(NUM_REQ),
  localparam int unsigned CntW = $clog2(MAX_BURST + 1)
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          wfull,
  output logic [IdxW-1:0]               owner,
  output logic                          busy
`ifdef AFIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [StallCntW-1:0]          stall_cnt
`endif
);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
  logic [IdxW-1:0] pick_idx;
  logic            pick_vld;
  logic [IdxW-1:0] next_ptr;
  logic            own_req;
  logic            xfer;

  afifo_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .req   (req),
    .rr_ptr(rr_ptr_q),
    .winner(pick_idx),
    .valid (pick_vld)
  );

  assign own_req  = req[owner_q];
  assign xfer     = (state_q == StBurst) && own_req && !wfull && !wrst;
  assign next_ptr = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + IdxW'(1);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d    = StBurst;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      StBurst: begin
        if (!own_req) begin
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end else if (!wfull) begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
          if (beat_cnt_q == CntW'(MAX_BURST - 1)) begin
            state_d  = StIdle;
            rr_ptr_d = next_ptr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced quiet while wrst is high so a burst never writes in the reset cycle.
  always_comb begin
    gnt   = '0;
    winc  = 1'b0;
    wdata = '0;
    busy  = 1'b0;
    owner = '0;
    if (!wrst && (state_q == StBurst)) begin
      busy         = 1'b1;
      owner        = owner_q;
      wdata        = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
      gnt[owner_q] = xfer;
      winc         = xfer;
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef AFIFO_WR_ARB_STALL_CNT_EN
  logic [StallCntW-1:0] stall_cnt_q;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      stall_cnt_q <= '0;
    end else if (busy && own_req && wfull && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + StallCntW'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Directed self-checking bench for afifo_wr_arbiter (default and MAX_BURST=1 instances).
module tb_afifo_wr_arbiter;

  logic         wclk = 1'b0;
  logic         wrst;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   gnt;
  logic         winc;
  logic [31:0]  wdata;
  logic         wfull;
  logic [1:0]   owner;
  logic         busy;

  logic [1:0]   req_b;
  logic [15:0]  req_data_b;
  logic [1:0]   gnt_b;
  logic         winc_b;
  logic [7:0]   wdata_b;
  logic         wfull_b;
  logic [0:0]   owner_b;
  logic         busy_b;

`ifdef AFIFO_WR_ARB_STALL_CNT_EN
  logic [15:0]  stall_cnt;
  logic [15:0]  stall_cnt_b;
`endif

  logic [31:0] slice_c [4];
  int tests = 0;
  int fails = 0;

  always #5 wclk = ~wclk;

  afifo_wr_arbiter #(
    .DATA_WIDTH(32),
    .NUM_REQ   (4),
    .MAX_BURST (8)
  ) dut (
    .wclk    (wclk),
    .wrst    (wrst),
    .req     (req),
    .req_data(req_data),
    .gnt     (gnt),
    .winc    (winc),
    .wdata   (wdata),
    .wfull   (wfull),
    .owner   (owner),
    .busy    (busy)
`ifdef AFIFO_WR_ARB_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  afifo_wr_arbiter #(
    .DATA_WIDTH(8),
    .NUM_REQ   (2),
    .MAX_BURST (1)
  ) dut_b (
    .wclk    (wclk),
    .wrst    (wrst),
    .req     (req_b),
    .req_data(req_data_b),
    .gnt     (gnt_b),
    .winc    (winc_b),
    .wdata   (wdata_b),
    .wfull   (wfull_b),
    .owner   (owner_b),
    .busy    (busy_b)
`ifdef AFIFO_WR_ARB_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt_b)
`endif
  );

  task automatic tick;
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset;
    wrst    = 1'b1;
    req     = '0;
    wfull   = 1'b0;
    req_b   = '0;
    wfull_b = 1'b0;
    tick();
    wrst = 1'b0;
  endtask

  task automatic test_reset;
    wrst  = 1'b1;
    req   = 4'hF;
    wfull = 1'b0;
    req_b = 2'b11;
    #1;
    tests++; if (gnt !== 4'b0) begin fails++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    tests++; if (winc !== 1'b0) begin fails++; $display("FAIL reset_winc: got %b want 0", winc); end
    tests++; if (wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata: got %h want 0", wdata); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tick();
    wfull = 1'b1;
    #1;
    tests++; if (winc !== 1'b0) begin fails++; $display("FAIL reset_winc_wfull: got %b want 0", winc); end
    tick();
    wrst = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    tests++; if (owner !== 2'd0) begin fails++; $display("FAIL post_reset_owner: got %0d want 0", owner); end
    tests++; if (gnt !== 4'b0) begin fails++; $display("FAIL post_reset_gnt: got %b want 0000", gnt); end
    tick();
  endtask

  // V1: single requester, two full bursts separated by one IDLE cycle.
  task automatic test_single_burst;
    logic exp_w;
    int   writes;
    do_reset();
    req    = 4'b0001;
    writes = 0;
    for (int c = 0; c < 20; c++) begin
      exp_w = ((c >= 1) && (c <= 8)) || ((c >= 10) && (c <= 17)) || (c == 19);
      #1;
      tests++; if (winc !== exp_w) begin fails++; $display("FAIL v1_winc c=%0d: got %b want %b", c, winc, exp_w); end
      tests++; if (gnt !== (exp_w ? 4'b0001 : 4'b0000)) begin fails++; $display("FAIL v1_gnt c=%0d: got %b want %b", c, gnt, exp_w); end
      if ((c <= 17) && (winc === 1'b1)) writes++;
      tick();
    end
    tests++; if (writes != 16) begin fails++; $display("FAIL v1_writes: got %0d want 16", writes); end
  endtask

  // V2: all requesting; owners rotate 0,1,2,3,0 with 8 beats each.
  task automatic test_round_robin;
    logic [1:0] exp_o;
    logic [3:0] exp_g;
    do_reset();
    req = 4'hF;
    for (int t = 0; t < 5; t++) begin
      exp_o = 2'(t % 4);
      exp_g = 4'b0001 << exp_o;
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL v2_idle_busy t=%0d: got %b want 0", t, busy); end
      tests++; if (winc !== 1'b0) begin fails++; $display("FAIL v2_idle_winc t=%0d: got %b want 0", t, winc); end
      tick();
      for (int b = 0; b < 8; b++) begin
        #1;
        tests++; if (owner !== exp_o) begin fails++; $display("FAIL v2_owner t=%0d b=%0d: got %0d want %0d", t, b, owner, exp_o); end
        tests++; if (gnt !== exp_g) begin fails++; $display("FAIL v2_gnt t=%0d b=%0d: got %b want %b", t, b, gnt, exp_g); end
        tests++; if (wdata !== slice_c[exp_o]) begin fails++; $display("FAIL v2_wdata t=%0d b=%0d: got %h want %h", t, b, wdata, slice_c[exp_o]); end
        tick();
      end
    end
  endtask

  // V3: owner 2 stalls on wfull after 3 beats, then finishes the burst.
  task automatic test_wfull_stall;
    do_reset();
    req = 4'b0100;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL v3_idle_busy: got %b want 0", busy); end
    tick();
    for (int b = 0; b < 3; b++) begin
      #1;
      tests++; if (winc !== 1'b1) begin fails++; $display("FAIL v3_pre_winc b=%0d: got %b want 1", b, winc); end
      tick();
    end
    wfull = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      tests++; if (winc !== 1'b0) begin fails++; $display("FAIL v3_stall_winc s=%0d: got %b want 0", s, winc); end
      tests++; if (gnt !== 4'b0) begin fails++; $display("FAIL v3_stall_gnt s=%0d: got %b want 0000", s, gnt); end
      tests++; if (owner !== 2'd2) begin fails++; $display("FAIL v3_stall_owner s=%0d: got %0d want 2", s, owner); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL v3_stall_busy s=%0d: got %b want 1", s, busy); end
      tick();
      tests++; if (dut.beat_cnt_q !== 4'd3) begin fails++; $display("FAIL v3_beat_cnt s=%0d: got %0d want 3", s, dut.beat_cnt_q); end
    end
    wfull = 1'b0;
    for (int b = 0; b < 5; b++) begin
      #1;
      tests++; if (winc !== 1'b1) begin fails++; $display("FAIL v3_post_winc b=%0d: got %b want 1", b, winc); end
      tests++; if (wdata !== slice_c[2]) begin fails++; $display("FAIL v3_post_wdata b=%0d: got %h want %h", b, wdata, slice_c[2]); end
      tick();
    end
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL v3_exit_busy: got %b want 0", busy); end
    tests++; if (dut.rr_ptr_q !== 2'd3) begin fails++; $display("FAIL v3_rr_ptr: got %0d want 3", dut.rr_ptr_q); end
    req = 4'hF;
    tick();
    #1;
    tests++; if (owner !== 2'd3) begin fails++; $display("FAIL v3_next_owner: got %0d want 3", owner); end
  endtask

  // V4: owner 1 releases after 2 beats; waiting requester 3 takes over.
  task automatic test_release;
    do_reset();
    req = 4'b1010;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL v4_idle_busy: got %b want 0", busy); end
    tick();
    for (int b = 0; b < 2; b++) begin
      #1;
      tests++; if (owner !== 2'd1) begin fails++; $display("FAIL v4_owner b=%0d: got %0d want 1", b, owner); end
      tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL v4_gnt b=%0d: got %b want 0010", b, gnt); end
      tick();
    end
    req = 4'b1000;
    #1;
    tests++; if (winc !== 1'b0) begin fails++; $display("FAIL v4_release_winc: got %b want 0", winc); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL v4_release_busy: got %b want 1", busy); end
    tick();
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL v4_idle2_busy: got %b want 0", busy); end
    tests++; if (winc !== 1'b0) begin fails++; $display("FAIL v4_idle2_winc: got %b want 0", winc); end
    tick();
    #1;
    tests++; if (owner !== 2'd3) begin fails++; $display("FAIL v4_new_owner: got %0d want 3", owner); end
    tests++; if (gnt !== 4'b1000) begin fails++; $display("FAIL v4_new_gnt: got %b want 1000", gnt); end
    tests++; if (wdata !== slice_c[3]) begin fails++; $display("FAIL v4_new_wdata: got %h want %h", wdata, slice_c[3]); end
    tick();
  endtask

  // V5: reset pulse on owner 0's 4th beat drops the tenure.
  task automatic test_reset_mid_burst;
    do_reset();
    req = 4'b0001;
    tick();
    for (int b = 0; b < 3; b++) begin
      #1;
      tests++; if (winc !== 1'b1) begin fails++; $display("FAIL v5_pre_winc b=%0d: got %b want 1", b, winc); end
      tick();
    end
    wrst = 1'b1;
    #1;
    tests++; if (winc !== 1'b0) begin fails++; $display("FAIL v5_rst_winc: got %b want 0", winc); end
    tests++; if (gnt !== 4'b0) begin fails++; $display("FAIL v5_rst_gnt: got %b want 0000", gnt); end
    tests++; if (wdata !== 32'h0) begin fails++; $display("FAIL v5_rst_wdata: got %h want 0", wdata); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL v5_rst_busy: got %b want 0", busy); end
    tick();
    wrst = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL v5_after_busy: got %b want 0", busy); end
    tests++; if (owner !== 2'd0) begin fails++; $display("FAIL v5_after_owner: got %0d want 0", owner); end
    tests++; if (dut.rr_ptr_q !== 2'd0) begin fails++; $display("FAIL v5_after_rr_ptr: got %0d want 0", dut.rr_ptr_q); end
    tests++; if (winc !== 1'b0) begin fails++; $display("FAIL v5_after_winc: got %b want 0", winc); end
    tick();
    #1;
    tests++; if (winc !== 1'b1) begin fails++; $display("FAIL v5_restart_winc: got %b want 1", winc); end
    tick();
  endtask

  // MAX_BURST=1: each tenure is one beat then one IDLE cycle, alternating owners.
  task automatic test_max_burst_one;
    logic       exp_w;
    logic [0:0] exp_o;
    logic [1:0] exp_g;
    do_reset();
    req_b      = 2'b11;
    req_data_b = 16'hB1A0;
    for (int c = 0; c < 8; c++) begin
      exp_w = (c % 2) == 1;
      exp_o = 1'((c / 2) % 2);
      exp_g = exp_w ? (2'b01 << exp_o) : 2'b00;
      #1;
      tests++; if (winc_b !== exp_w) begin fails++; $display("FAIL mb1_winc c=%0d: got %b want %b", c, winc_b, exp_w); end
      tests++; if (gnt_b !== exp_g) begin fails++; $display("FAIL mb1_gnt c=%0d: got %b want %b", c, gnt_b, exp_g); end
      if (exp_w) begin
        tests++; if (owner_b !== exp_o) begin fails++; $display("FAIL mb1_owner c=%0d: got %0d want %0d", c, owner_b, exp_o); end
        tests++; if (wdata_b !== (exp_o ? 8'hB1 : 8'hA0)) begin fails++; $display("FAIL mb1_wdata c=%0d: got %h", c, wdata_b); end
      end
      tick();
    end
  endtask

`ifdef AFIFO_WR_ARB_STALL_CNT_EN
  // V6: ten stalled cycles count to 10; a saturated counter holds.
  task automatic test_stall_cnt;
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    wfull = 1'b1;
    for (int s = 0; s < 10; s++) tick();
    wfull = 1'b0;
    #1;
    tests++; if (stall_cnt !== 16'd10) begin fails++; $display("FAIL v6_stall_cnt: got %0d want 10", stall_cnt); end
    wfull = 1'b1;
    force dut.stall_cnt_q = 16'hFFFF;
    tick();
    release dut.stall_cnt_q;
    tick();
    tick();
    #1;
    tests++; if (stall_cnt !== 16'hFFFF) begin fails++; $display("FAIL v6_saturate: got %h want ffff", stall_cnt); end
    wfull = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    slice_c[0] = 32'hAAAA_0000;
    slice_c[1] = 32'hBBBB_0001;
    slice_c[2] = 32'hCCCC_0002;
    slice_c[3] = 32'hDDDD_0003;
    req_data   = {slice_c[3], slice_c[2], slice_c[1], slice_c[0]};
    req_data_b = 16'hB1A0;
    wrst       = 1'b1;
    req        = '0;
    wfull      = 1'b0;
    req_b      = '0;
    wfull_b    = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_wfull_stall();
    test_release();
    test_reset_mid_burst();
    test_max_burst_one();
`ifdef AFIFO_WR_ARB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
